// File: rtl/result_writer_pkg.sv
// Shared types and defaults for the result writer and the accelerator wrapper.
// Holds the writer FSM state enum and the default data/address widths.
package result_writer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StFinish
  } rw_state_e;

  localparam int unsigned RwDw = 21;
  localparam int unsigned RwAw = 8;

  // States in which the FIFO accepts results and drains to memory.
  function automatic logic rw_active(rw_state_e s);
    return (s == StRun) || (s == StFlush);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small power-of-two FIFO buffering accelerator results ahead of the memory port.
// Synchronous clear has priority over push/pop; the head is always visible.
module result_fifo #(
  parameter int unsigned DW    = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  always_comb begin
    full_o  = (cnt_q == CntW'(DEPTH));
    empty_o = (cnt_q == '0);
    head_o  = mem_q[rptr_q];
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  a_not_full_and_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(full_o && empty_o));

endmodule

// File: rtl/result_writer.sv
// Buffers accelerator results in a FIFO and writes them to sequential memory addresses.
// Define RESULT_WRITER_OVF_EN to track dropped results on the sticky overflow output.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int unsigned DW    = RwDw,
  parameter int unsigned AW    = RwAw,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  input  logic          acc_done,
  input  logic          mem_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          full,
  output logic          all_done,
  output logic          overflow
);

  rw_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] head;
  logic          empty;
  logic          active, clr, push, pop;

  always_comb begin
    active = rw_active(state_q);
    clr    = (state_q == StIdle) & start;
    // Admission uses the registered full flag, so a same-cycle pop never frees a slot.
    push   = active & wr_req & ~full;
    pop    = mem_wr & mem_ready;
  end

  result_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .push_i (push),
    .data_i (wr_data),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (acc_done) state_d = StFlush;
      // An empty FIFO means no beat is outstanding; a late result keeps us flushing.
      StFlush:  if (empty && !wr_req) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    all_done = (state_q == StFinish);
    mem_wr   = active & ~empty;
    mem_data = mem_wr ? head : '0;
    mem_addr = addr_q;
  end

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (pop) begin
      addr_d = addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

`ifdef RESULT_WRITER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (active && wr_req && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_wr && !mem_ready) |=> (mem_wr && $stable(mem_addr) && $stable(mem_data)));

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    all_done |=> !all_done);

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 21, result word width (matches accelerator wr_data).
- AW, 8, result memory address width.
- DEPTH, 4, FIFO entries (power of two, >=2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin batch; sampled only in IDLE.
- wr_req  in  1  accelerator result valid, one word per cycle high.
- wr_data  in  DW  accelerator result word.
- acc_done  in  1  accelerator finished batch (pulse).
- mem_ready  in  1  memory accepts current write.
- mem_wr  out  1  memory write request.
- mem_addr  out  AW  write address.
- mem_data  out  DW  write data.
- full  out  1  FIFO holds DEPTH entries.
- all_done  out  1  one-cycle pulse: batch fully written.
- overflow  out  1  sticky: a result was dropped.

Function
REQ-003 FSM states SHALL be IDLE, RUN, FLUSH, FINISH.
REQ-004 IDLE: start=1 -> RUN next cycle; mem_addr, FIFO, and overflow cleared at that edge.
REQ-005 RUN: acc_done=1 -> FLUSH; FLUSH: FIFO empty and no beat in flight -> FINISH; FINISH -> IDLE unconditionally.
REQ-006 all_done SHALL be 1 exactly during the single FINISH cycle.
REQ-007 Push SHALL occur when wr_req=1, state is RUN or FLUSH, and full=0 before this cycle's pop.
REQ-008 wr_req with full=1 SHALL drop the word even if a pop occurs in the same cycle; it sets overflow.
REQ-009 wr_req in IDLE or FINISH SHALL be ignored without setting overflow.
REQ-010 mem_wr SHALL be 1 when state is RUN or FLUSH and FIFO non-empty; mem_data = FIFO head.
REQ-011 Beat completes on mem_wr & mem_ready: pop head; mem_addr increments by 1.
REQ-012 mem_addr SHALL wrap from 2^AW-1 to 0 without error.
REQ-013 mem_wr, mem_addr, and mem_data SHALL hold stable while mem_wr=1 and mem_ready=0.
REQ-014 Latency: word pushed at edge n SHALL appear on mem_wr/mem_data from cycle n+1 when FIFO was empty.
REQ-015 Simultaneous push and pop when not full SHALL keep occupancy constant and preserve order.
REQ-016 acc_done with empty FIFO SHALL give FLUSH for one cycle, then FINISH.
REQ-017 start outside IDLE and acc_done outside RUN SHALL be ignored.

Reset
REQ-018 rst=1 SHALL asynchronously force state IDLE, FIFO empty, mem_addr=0, overflow=0.
REQ-019 During reset, mem_wr=0, mem_data=0, full=0, all_done=0.
REQ-020 Reset mid-batch SHALL discard queued words; no write completes after rst asserts.

Configuration
REQ-021 Macro RESULT_WRITER_OVF_EN SHALL control overflow tracking.
- Defined: overflow behaves per REQ-008.
- Undefined: overflow tied 0; the port remains; dropping per REQ-008 is unchanged.

Structure
REQ-022 The shared package SHALL hold the FSM state enum and the DW/AW defaults, for reuse by the accelerator wrapper.
REQ-023 The FIFO SHALL be a sub-module result_fifo: DW-wide, DEPTH-deep, with push/pop/full/empty/head and a synchronous clear.

Verification
REQ-024 Bench SHALL cover these scenarios:
- start; 3 wr_req (0x00001, 0x00002, 0x00003) with mem_ready=1; acc_done -> writes to addr 0,1,2 in order, then all_done for 1 cycle.
- mem_ready=0, 5 wr_req, DEPTH=4 -> full=1 after 4; 5th dropped; overflow=1 (macro on) or 0 (macro off); 4 words written after mem_ready=1.
- mem_ready toggles 0/1 every cycle -> mem_data/mem_addr unchanged across stall cycles.
- Address starts at 254 via preceding batch; 3 writes -> addresses 254, 255, 0.
- acc_done in RUN with empty FIFO -> FLUSH 1 cycle, FINISH 1 cycle, IDLE.
- rst pulse with 2 words queued -> mem_wr=0 immediately; after release, state IDLE, addr 0, no writes.
